// File: rtl/usb_pkg.sv
// Shared USB definitions: PID bytes, CRC16 constants, IN transmitter states
// and the byte-wide CRC16 update used by the CRC sub-module.
package usb_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REWIND,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_WAIT_HS,
    ST_HS
  } in_tx_state_e;

  // One byte through the reflected CRC16, LSB of the byte first.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_usb.sv
// USB CRC16 register with byte-parallel update. The caller qualifies clr_i
// and en_i with the bit-rate gate; clear takes priority over update.
module crc16_usb
  import usb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value if the current byte is folded in.
  always_comb begin
    crc_d = crc16_update(crc_q, data_i);
  end

  // CRC register: reset/clear to the init value, otherwise fold bytes in.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q <= CRC16_INIT;
    end else if (clr_i) begin
      crc_q <= CRC16_INIT;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/in_pkt_tx.sv
// IN endpoint packet transmitter: answers an IN token with STALL, NAK or a
// DATA0/DATA1 packet read from a rewindable FIFO, then waits for the host
// handshake to commit or retransmit. Everything advances on clk_gate_i only.
module in_pkt_tx
  import usb_pkg::*;
#(
  parameter int IN_MAXPACKETSIZE = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic       in_token_i,
  input  logic       ack_i,
  input  logic       timeout_i,
  input  logic       stall_i,
  input  logic       toggle_clr_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_req_o,
  output logic       in_ready_o,
  output logic       in_data_ack_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_last_o,
  output logic       busy_o
);

  localparam logic [6:0] MAX_CNT = 7'(IN_MAXPACKETSIZE);

  in_tx_state_e state_q, state_d;
  logic         toggle_q, toggle_d;
  logic         zlp_pend_q, zlp_pend_d;
  logic [6:0]   count_q, count_d;
  logic         in_req_q, in_req_d;
  logic         in_ready_q, in_ready_d;
  logic         in_data_ack_q, in_data_ack_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         tx_last_q, tx_last_d;
  logic         crc_clr, crc_en;
  logic [15:0]  crc;

  crc16_usb u_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clk_gate_i & crc_clr),
    .en_i   (clk_gate_i & crc_en),
    .data_i (tx_data_q),
    .crc_o  (crc)
  );

  // Next-state and registered-output logic. In DATA a transferred byte is
  // followed by one gap cycle so the FIFO head has advanced before reloading.
  always_comb begin
    state_d       = state_q;
    toggle_d      = toggle_q;
    zlp_pend_d    = zlp_pend_q;
    count_d       = count_q;
    in_req_d      = 1'b0;
    in_ready_d    = 1'b0;
    in_data_ack_d = 1'b0;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    tx_last_d     = tx_last_q;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        if (in_token_i) begin
          if (stall_i) begin
            state_d    = ST_HS;
            tx_data_d  = PID_STALL;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
          end else begin
            state_d    = ST_REWIND;
            in_ready_d = 1'b1;
            in_req_d   = 1'b1;
            count_d    = 7'd0;
            crc_clr    = 1'b1;
          end
        end
      end

      ST_REWIND: begin
        state_d = ST_PID;
      end

      ST_PID: begin
        if (!tx_valid_q) begin
          if (!in_valid_i && !zlp_pend_q) begin
            state_d    = ST_HS;
            tx_data_d  = PID_NAK;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
          end else begin
            tx_data_d  = toggle_q ? PID_DATA1 : PID_DATA0;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
          end
        end else if (tx_ready_i) begin
          if (in_valid_i) begin
            state_d   = ST_DATA;
            tx_data_d = in_data_i;
          end else begin
            state_d   = ST_CRC_LO;
            tx_data_d = ~crc[7:0];
          end
        end
      end

      ST_DATA: begin
        if (tx_valid_q) begin
          if (tx_ready_i) begin
            crc_en     = 1'b1;
            count_d    = count_q + 7'd1;
            in_ready_d = 1'b1;
            tx_valid_d = 1'b0;
          end
        end else if (!in_ready_q) begin
          tx_valid_d = 1'b1;
          if ((count_q == MAX_CNT) || !in_valid_i) begin
            state_d   = ST_CRC_LO;
            tx_data_d = ~crc[7:0];
          end else begin
            tx_data_d = in_data_i;
          end
        end
      end

      ST_CRC_LO: begin
        if (tx_ready_i) begin
          state_d   = ST_CRC_HI;
          tx_data_d = ~crc[15:8];
          tx_last_d = 1'b1;
        end
      end

      ST_CRC_HI: begin
        if (tx_ready_i) begin
          state_d    = ST_WAIT_HS;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end

      ST_WAIT_HS: begin
        if (ack_i) begin
          state_d       = ST_IDLE;
          in_ready_d    = 1'b1;
          in_data_ack_d = 1'b1;
          toggle_d      = ~toggle_q;
          zlp_pend_d    = (count_q == MAX_CNT);
        end else if (timeout_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_HS: begin
        if (tx_ready_i) begin
          state_d    = ST_IDLE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase

    if (toggle_clr_i) begin
      toggle_d   = 1'b0;
      zlp_pend_d = 1'b0;
    end
  end

  // State and output registers, advanced only on the bit-rate gate.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      toggle_q      <= 1'b0;
      zlp_pend_q    <= 1'b0;
      count_q       <= 7'd0;
      in_req_q      <= 1'b0;
      in_ready_q    <= 1'b0;
      in_data_ack_q <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      tx_last_q     <= 1'b0;
    end else if (clk_gate_i) begin
      state_q       <= state_d;
      toggle_q      <= toggle_d;
      zlp_pend_q    <= zlp_pend_d;
      count_q       <= count_d;
      in_req_q      <= in_req_d;
      in_ready_q    <= in_ready_d;
      in_data_ack_q <= in_data_ack_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_last_q     <= tx_last_d;
    end
  end

  assign in_req_o      = in_req_q;
  assign in_ready_o    = in_ready_q;
  assign in_data_ack_o = in_data_ack_q;
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign tx_last_o     = tx_last_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/in_pkt_tx.md
IN_PKT_TX -- requirements
Module: in_pkt_tx

Interface
REQ-001 SHALL have parameter IN_MAXPACKETSIZE, default 8, max payload bytes per DATA packet (1..64).
REQ-002 SHALL have ports, clock and reset first:
- clk_i in 1: 12MHz*BIT_SAMPLES clock.
- rstn_i in 1: reset, asynchronous, active-low.
- clk_gate_i in 1: one-cycle enable every BIT_SAMPLES cycles.
- in_token_i in 1: IN token for this endpoint received.
- ack_i in 1: ACK handshake received.
- timeout_i in 1: handshake wait expired.
- stall_i in 1: endpoint halted.
- toggle_clr_i in 1: force next PID to DATA0.
- in_data_i in 8: FIFO head byte.
- in_valid_i in 1: FIFO has an unsent byte.
- in_req_o out 1: rewind FIFO to first unacked byte.
- in_ready_o out 1: FIFO command strobe.
- in_data_ack_o out 1: commit sent bytes.
- tx_data_o out 8: byte to transmitter.
- tx_valid_o out 1: tx_data_o valid.
- tx_ready_i in 1: transmitter accepts byte.
- tx_last_o out 1: current byte ends the packet.
- busy_o out 1: FSM not in IDLE.
REQ-003 All inputs except rstn_i SHALL be sampled, and all outputs updated, only when clk_gate_i=1.

Function
REQ-004 FSM states SHALL be IDLE, REWIND, PID, DATA, CRC_LO, CRC_HI, WAIT_HS, HS.
REQ-005 IDLE + in_token_i: stall_i=1 -> HS, sending STALL 0x1E; otherwise -> REWIND.
REQ-006 REWIND SHALL pulse in_ready_o=1 with in_req_o=1 for exactly one gated cycle, then -> PID.
REQ-007 PID: if in_valid_i=0 and zlp_pend=0 -> HS, sending NAK 0x5A. Otherwise send DATA0 0xC3 / DATA1 0x4B per toggle; tx_valid_o held until tx_ready_i.
REQ-008 A byte SHALL transfer when clk_gate_i, tx_valid_o and tx_ready_i are all 1; tx_data_o/tx_valid_o SHALL stay stable until then.
REQ-009 DATA: each transferred payload byte SHALL pulse in_ready_o with in_req_o=0 and in_data_ack_o=0 for one gated cycle, advancing the FIFO.
REQ-010 DATA SHALL end (-> CRC_LO) when byte count reaches IN_MAXPACKETSIZE or in_valid_i=0. A zero-length packet SHALL go PID -> CRC_LO.
REQ-011 CRC16: reflected poly 0xA001, init 0xFFFF, over payload only, complemented. Low byte sent in CRC_LO, high byte in CRC_HI; tx_last_o=1 on CRC_HI. Byte count is 7 bits.
REQ-012 WAIT_HS on ack_i: pulse in_ready_o with in_data_ack_o=1, toggle data PID, set zlp_pend=1 iff count==IN_MAXPACKETSIZE (else clear), -> IDLE.
REQ-013 WAIT_HS on timeout_i -> IDLE with no FIFO command and toggle unchanged; the next token's REWIND retransmits. ack_i and timeout_i together: ack_i wins.
REQ-014 HS SHALL send one byte with tx_last_o=1, then -> IDLE; toggle and FIFO untouched.
REQ-015 in_token_i outside IDLE SHALL be ignored.
REQ-016 toggle_clr_i SHALL clear toggle and zlp_pend in any state; on the same cycle as ack_i, the clear wins.
REQ-017 At most one of REWIND/byte/ack strobes SHALL occur per gated cycle.

Reset
REQ-018 rstn_i low SHALL force IDLE; toggle=DATA0, zlp_pend=0, count=0, CRC=0xFFFF; all outputs 0. Mid-packet reset SHALL abort without FIFO commit.

Structure
REQ-019 PID constants and CRC16 polynomial/init SHALL live in shared package usb_pkg.
REQ-020 CRC SHALL be sub-module crc16_usb (8-bit parallel update, clear, enable).

Verification
REQ-021 IN_MAXPACKETSIZE=16, FIFO holds ASCII "123456789", token -> C3 31..39 C8 B4; tx_last on B4; 9 byte strobes; ack_i -> one in_data_ack_o pulse, toggle=DATA1.
REQ-022 Empty FIFO, zlp_pend=0, token -> single byte 5A, no FIFO strobe except REWIND.
REQ-023 8 bytes queued, default param, token+ack -> C3+8 bytes+CRC; next token, FIFO empty -> ZLP 4B 00 00; next token -> 5A.
REQ-024 Packet sent, timeout_i; token again -> in_req_o rewind, identical bytes with same PID C3.
REQ-025 stall_i=1, token -> 1E only; tx_ready_i held low 5 gated cycles during DATA -> tx_data_o stable, no extra strobes.
REQ-026 rstn_i low during DATA -> outputs 0, no in_data_ack_o; next token restarts with C3.
